// File: rtl/wb_bram_slave.sv
// WISHBONE classic-cycle slave around a single-port block RAM with byte-lane
// writes, selectable read latency and error termination for unmapped words.
module wb_bram_slave #(
   parameter int DAT_W    = 32,
   parameter int ADR_W    = 3,
   parameter int DEPTH    = 8,
   parameter int READ_LAT = 1
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic               CYC_I,
   input  logic               STB_I,
   input  logic               WE_I,
   input  logic [ADR_W-1:0]   ADR_I,
   input  logic [DAT_W/8-1:0] SEL_I,
   input  logic [DAT_W-1:0]   DAT_I,
   output logic [DAT_W-1:0]   DAT_O,
   output logic               ACK_O,
   output logic               ERR_O
);

   localparam int              NB      = DAT_W / 8;
   localparam logic [ADR_W:0]  DEPTH_C = (ADR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      TERM    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [DAT_W-1:0]   dat_q, dat_d;
   logic [DAT_W-1:0]   ram_rd_q;
   logic [DAT_W-1:0]   rd_word_s;
   logic               req_s;
   logic               oor_s;
   logic               mem_we_s;
   logic               rd_en_s;
   logic [DAT_W-1:0]   mem_q [DEPTH];

   assign req_s     = CYC_I & STB_I;
   assign oor_s     = ({1'b0, ADR_I} >= DEPTH_C);
   assign rd_word_s = mem_q[ADR_I];

   // RAM array: byte-lane write port plus registered read port used by the two-cycle path
   always_ff @(posedge CLK_I) begin
      if (mem_we_s) begin
         for (int n = 0; n < NB; n++) begin
            if (SEL_I[n]) begin
               mem_q[ADR_I][8*n +: 8] <= DAT_I[8*n +: 8];
            end
         end
      end
      if (rd_en_s) begin
         ram_rd_q <= mem_q[ADR_I];
      end
   end

   // Handshake state and registered bus outputs
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= {DAT_W{1'b0}};
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   // Next-state decode; a write coinciding with reset is suppressed here
   always_comb begin
      state_d  = state_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = dat_q;
      mem_we_s = 1'b0;
      rd_en_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s && oor_s) begin
               err_d   = 1'b1;
               state_d = TERM;
            end else if (req_s && WE_I) begin
               mem_we_s = ~RST_I;
               ack_d    = 1'b1;
               state_d  = TERM;
            end else if (req_s) begin
               rd_en_s = 1'b1;
               if (READ_LAT == 1) begin
                  dat_d   = rd_word_s;
                  ack_d   = 1'b1;
                  state_d = TERM;
               end else begin
                  state_d = RD_WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (CYC_I) begin
               dat_d   = ram_rd_q;
               ack_d   = 1'b1;
               state_d = TERM;
            end else begin
               state_d = IDLE;
            end
         end
         TERM: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign DAT_O = dat_q;
   assign ACK_O = ack_q;
   assign ERR_O = err_q;

endmodule
